// File: rtl/stream_range_source_if.sv
// stream_range_source_if
//   Bundles the call handshake, the call arguments, the output stream and the
//   completion report of stream_range_source.
//   Signals:
//     in_valid / in_ready    call request handshake (caller -> block)
//     start, step, count     call arguments, sampled on the accepting edge
//     sOut / sOut_valid /    output element stream (block -> downstream)
//       sOut_ready
//     out_valid / out_ready  completion report handshake (block -> caller)
//     emitted                elements transferred in the last call
//   Modports:
//     master  caller / environment side
//     slave   stream_range_source side
interface stream_range_source_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] start;
  logic [N-1:0] step;
  logic [N-1:0] count;
  logic [N-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready;
  logic [N-1:0] emitted;

  modport master (
    output in_valid, out_ready, start, step, count, sOut_ready,
    input  in_ready, out_valid, sOut, sOut_valid, emitted
  );

  modport slave (
    input  in_valid, out_ready, start, step, count, sOut_ready,
    output in_ready, out_valid, sOut, sOut_valid, emitted
  );
endinterface

// File: rtl/stream_range_source.sv
// stream_range_source
//   On an accepted call it emits start, start+step, start+2*step, ... (count
//   elements, modulo 2^N) on a valid/ready stream, then raises a completion
//   report carrying the number of elements transferred.
//   Ports:
//     clk   rising-edge clock
//     nRST  asynchronous active-low reset; abandons any call in progress
//     bus   stream_range_source_if.slave (call, stream and completion signals)
//   All outputs come straight from registers.

// Protocol checker: the three handshake status outputs are mutually exclusive
// and a stalled stream element holds still until it is taken.
module stream_range_source_chk #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         nRST,
  input logic         in_ready,
  input logic         out_valid,
  input logic         sout_valid,
  input logic         sout_ready,
  input logic [N-1:0] sout
);
  a_status_onehot: assert property (
    @(posedge clk) disable iff (!nRST)
      $onehot({in_ready, out_valid, sout_valid})
  );

  a_stall_stable: assert property (
    @(posedge clk) disable iff (!nRST)
      (sout_valid && !sout_ready) |=> (sout_valid && $stable(sout))
  );
endmodule

module stream_range_source #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  nRST,
  stream_range_source_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t       state_r;
  logic [N-1:0] step_r;
  logic [N-1:0] remaining_r;
  logic [N-1:0] sout_r;
  logic [N-1:0] emitted_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         sout_valid_r;

  logic         call_s;
  logic         xfer_s;
  logic         done_ack_s;
  logic         last_s;

  // Handshake strobes derived from the registered status flags.
  always_comb begin
    call_s     = 1'b0;
    xfer_s     = 1'b0;
    done_ack_s = 1'b0;
    last_s     = 1'b0;
    if (bus.in_valid && in_ready_r) begin
      call_s = 1'b1;
    end else begin
      call_s = 1'b0;
    end
    if (sout_valid_r && bus.sOut_ready) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
    if (out_valid_r && bus.out_ready) begin
      done_ack_s = 1'b1;
    end else begin
      done_ack_s = 1'b0;
    end
    // remaining_r counts elements not yet transferred, including the one on sOut.
    if (remaining_r == ONE) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Call sequencer: state, argument latches and all registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r      <= ST_IDLE;
      step_r       <= ZERO;
      remaining_r  <= ZERO;
      sout_r       <= ZERO;
      emitted_r    <= ZERO;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      sout_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (call_s) begin
            step_r      <= bus.step;
            remaining_r <= bus.count;
            sout_r      <= bus.start;
            emitted_r   <= ZERO;
            in_ready_r  <= 1'b0;
            if (bus.count != ZERO) begin
              sout_valid_r <= 1'b1;
              state_r      <= ST_EMIT;
            end else begin
              // Empty call: go straight to the completion report.
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end

        ST_EMIT: begin
          if (xfer_s) begin
            emitted_r   <= emitted_r + ONE;
            remaining_r <= remaining_r - ONE;
            if (last_s) begin
              sout_valid_r <= 1'b0;
              out_valid_r  <= 1'b1;
              state_r      <= ST_DONE;
            end else begin
              // Wraps silently modulo 2^N; a negative step is just its
              // two's-complement bit pattern.
              sout_r <= sout_r + step_r;
            end
          end
        end

        ST_DONE: begin
          if (done_ack_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          state_r      <= ST_IDLE;
          in_ready_r   <= 1'b1;
          out_valid_r  <= 1'b0;
          sout_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.sOut       = sout_r;
  assign bus.sOut_valid = sout_valid_r;
  assign bus.emitted    = emitted_r;

  stream_range_source_chk #(.N(N)) u_chk (
    .clk        (clk),
    .nRST       (nRST),
    .in_ready   (in_ready_r),
    .out_valid  (out_valid_r),
    .sout_valid (sout_valid_r),
    .sout_ready (bus.sOut_ready),
    .sout       (sout_r)
  );
endmodule
